// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM state
// encoding and parity-mode selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } TxState;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate flag.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       r_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_count   = r_wptr - r_rptr;
  assign o_full    = (o_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_wptr == r_rptr);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  // Pointer update; reset flushes the queue by realigning both pointers.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately not reset; stale entries are never
  // visible because the pointers are, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: queued words are framed as
// start / DATA_BITS (LSB first) / optional parity / STOP_BITS stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 250000,
  parameter int BAUD_RATE       = 10000,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           r_reset,
  input  logic [DATA_BITS-1:0]           i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic                           o_tx,
  output logic                           o_busy,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW             = $clog2(CYCLES_PER_BIT);
  localparam int BW             = $clog2(DATA_BITS + 1);

  if (CYCLES_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CYCLES_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  TxState                  r_state;
  logic [CW-1:0]           r_cycle;
  logic [BW-1:0]           r_bit;
  logic [DATA_BITS-1:0]    r_shift;
  logic                    r_parity;
  logic                    r_tx;

  logic [DATA_BITS-1:0]    w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_bit_end;
  logic                    w_stop_end;

  // Ready looks only at full, so a same-cycle pop never opens a slot early.
  assign o_ready    = !w_full && !r_reset;
  assign w_push     = i_valid && o_ready;
  assign w_bit_end  = (r_cycle == CW'(CYCLES_PER_BIT - 1));
  assign w_stop_end = (r_state == STOP) && w_bit_end && (r_bit == BW'(STOP_BITS - 1));
  assign w_pop      = !w_empty && ((r_state == IDLE) || w_stop_end);

  assign o_tx         = r_tx;
  assign o_busy       = (r_state != IDLE) || (w_count != '0);
  assign o_fifo_count = w_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .r_reset (r_reset),
    .i_push  (w_push),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Frame FSM with bit/cycle counters; o_tx is registered from the current
  // state, so the line trails the state by one cycle throughout a frame.
  // NOTE: every state element here uses <= so all updates see the values from
  // before the edge; a blocking assignment would let later lines read new values.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_state  <= IDLE;
      r_cycle  <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
        PARITY:  r_tx <= r_parity;
        default: r_tx <= 1'b1;
      endcase

      if (r_state != IDLE) r_cycle <= w_bit_end ? '0 : r_cycle + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= (^w_head) ^ (PARITY_MODE == PARITY_ODD);
            r_cycle  <= '0;
            r_bit    <= '0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) r_state <= DATA;
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit == BW'(DATA_BITS - 1)) begin
              r_bit   <= '0;
              r_state <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) r_state <= STOP;
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_stop_end) begin
              r_bit <= '0;
              if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= (^w_head) ^ (PARITY_MODE == PARITY_ODD);
                r_state  <= START;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four parameterisations, random
// words, a cycle-level queue model for ready/count/busy and a frame decoder
// that rebuilds every expected bit from the word.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] vld;
  logic [8:0] dat [4];
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [2:0] cnt [4];

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  int g_push0;
  int g_fall;
  logic [8:0] wq [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1, 25 cycles per bit
  uart_tx_param #(.CLOCK_FREQUENCY(250000), .BAUD_RATE(10000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .r_reset(rst[0]), .i_data(dat[0][7:0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_fifo_count(cnt[0]));

  // 8E1, 5 cycles per bit
  uart_tx_param #(.CLOCK_FREQUENCY(50000), .BAUD_RATE(10000), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .r_reset(rst[1]), .i_data(dat[1][7:0]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_fifo_count(cnt[1]));

  // 8O2, 25 cycles per bit
  uart_tx_param #(.CLOCK_FREQUENCY(250000), .BAUD_RATE(10000), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .r_reset(rst[2]), .i_data(dat[2][7:0]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_fifo_count(cnt[2]));

  // 7N1, minimum 2 cycles per bit
  uart_tx_param #(.CLOCK_FREQUENCY(20000), .BAUD_RATE(10000), .DATA_BITS(7),
                  .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .r_reset(rst[3]), .i_data(dat[3][6:0]), .i_valid(vld[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_fifo_count(cnt[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Queue model: the transmitter takes the head whenever it is free and the
  // queue is non-empty; it is free again frame_len cycles after taking a word.
  task automatic drive_model(input int k, input int n, input int frame_len);
    int mcount = 0;
    int pushed = 0;
    int popped = 0;
    int last_pop = -1000000;
    int e;
    bit acc, pop, done;
    done = 1'b0;
    @(negedge clk);
    vld[k] = 1'b1;
    dat[k] = wq[0];
    for (int t = 0; t < n * frame_len + 100 && !done; t++) begin
      check($sformatf("u%0d_ready", k), rdy[k], mcount < 4);
      acc = vld[k] && rdy[k];
      e = cyc + 1;
      pop = (mcount > 0) && (e >= last_pop + frame_len);
      @(negedge clk);
      if (pop) begin
        last_pop = e;
        popped++;
      end
      mcount = mcount + int'(acc) - int'(pop);
      if (acc) begin
        if (pushed == 0) g_push0 = cyc;
        pushed++;
        if (pushed < n) dat[k] = wq[pushed];
        else vld[k] = 1'b0;
      end
      check($sformatf("u%0d_count", k), cnt[k], mcount);
      check($sformatf("u%0d_busy", k), busy[k], (mcount != 0) || (popped > 0 && cyc < last_pop + frame_len));
      if (pushed == n && popped == n && cyc >= last_pop + frame_len) done = 1'b1;
    end
    if (!done) check($sformatf("u%0d_stream_timeout", k), 0, 1);
    vld[k] = 1'b0;
  endtask

  // Frame decoder: rebuilds the expected line for each word and counts how
  // many cycles of every bit period show the required level.
  task automatic mon_frames(input int k, input int n, input int nbits, input int par,
                            input int stops, input int cpb);
    logic [13:0] bits;
    logic [8:0]  w;
    int nb, good;
    bit found;
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      if (i == 0) begin
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
          @(negedge clk);
          if (tx[k] === 1'b0) found = 1'b1;
        end
        if (!found) begin
          check($sformatf("u%0d_start_timeout", k), 0, 1);
          return;
        end
        g_fall = cyc;
      end else begin
        @(negedge clk);
      end
      bits = '0;
      bits[0] = 1'b0;
      for (int b = 0; b < nbits; b++) bits[1 + b] = w[b];
      nb = 1 + nbits;
      if (par != 0) begin
        bits[nb] = (par == 2) ? ~(^w) : (^w);
        nb = nb + 1;
      end
      for (int s = 0; s < stops; s++) begin
        bits[nb] = 1'b1;
        nb = nb + 1;
      end
      for (int j = 0; j < nb; j++) begin
        good = 0;
        for (int c = 0; c < cpb; c++) begin
          if (j != 0 || c != 0) @(negedge clk);
          if (tx[k] === bits[j]) good++;
        end
        check($sformatf("u%0d_f%0d_bit%0d", k, i, j), good, cpb);
      end
    end
  endtask

  task automatic stream(input int k, input int n, input int nbits, input int par,
                        input int stops, input int cpb);
    int len;
    len = (1 + nbits + ((par != 0) ? 1 : 0) + stops) * cpb;
    g_push0 = -100;
    g_fall = -1000;
    fork
      drive_model(k, n, len);
      mon_frames(k, n, nbits, par, stops, cpb);
    join
    check($sformatf("u%0d_latency", k), g_fall - g_push0, 2);
  endtask

  task automatic fill_random(input int n, input int nbits);
    for (int i = 0; i < n; i++) wq[i] = 9'($urandom) & ((9'd1 << nbits) - 9'd1);
  endtask

  task automatic reset_abort;
    bit found;
    int good;
    fill_random(3, 8);
    @(negedge clk);
    vld[0] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      dat[0] = wq[p];
      for (int t = 0; t < 10 && !rdy[0]; t++) @(negedge clk);
      @(negedge clk);
    end
    vld[0] = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      if (tx[0] === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) check("rst_start_timeout", 0, 1);
    repeat (110) @(negedge clk);
    check("rst_pre_bit3", tx[0], wq[0][3]);
    check("rst_pre_count", cnt[0], 2);
    rst[0] = 1'b1;
    #1 check("rst_ready_low", rdy[0], 0);
    @(negedge clk);
    check("rst_tx", tx[0], 1);
    check("rst_count", cnt[0], 0);
    check("rst_busy", busy[0], 0);
    rst[0] = 1'b0;
    #1 check("rst_ready_high", rdy[0], 1);
    good = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx[0] === 1'b1 && busy[0] === 1'b0 && cnt[0] === 3'd0) good++;
    end
    check("rst_quiet", good, 300);
  endtask

  initial begin
    rst = 4'hF;
    vld = 4'h0;
    for (int k = 0; k < 4; k++) dat[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("init_ready_low%0d", k), rdy[k], 0);
      check($sformatf("init_tx%0d", k), tx[k], 1);
      check($sformatf("init_busy%0d", k), busy[k], 0);
      check($sformatf("init_count%0d", k), cnt[k], 0);
    end
    rst = 4'h0;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("init_ready_high%0d", k), rdy[k], 1);

    // 8N1 single 0xA5, then a burst that overfills the FIFO
    wq[0] = 9'h0A5;
    stream(0, 1, 8, 0, 1, 25);
    fill_random(6, 8);
    stream(0, 6, 8, 0, 1, 25);

    // 8E1: 0xA5 gives parity 0
    wq[0] = 9'h0A5;
    for (int i = 1; i < 4; i++) wq[i] = 9'($urandom_range(0, 255));
    stream(1, 4, 8, 1, 1, 5);

    // 8O2: 0xA5 gives parity 1, two stop bits
    wq[0] = 9'h0A5;
    wq[1] = 9'($urandom_range(0, 255));
    stream(2, 2, 8, 2, 2, 25);

    // 7N1 at the minimum bit period: 0x7F then 0x00 back to back
    wq[0] = 9'h07F;
    wq[1] = 9'h000;
    stream(3, 2, 7, 0, 1, 2);
    fill_random(5, 7);
    stream(3, 5, 7, 0, 1, 2);

    // Reset in the middle of a frame, then a clean frame afterwards
    reset_abort();
    fill_random(1, 8);
    stream(0, 1, 8, 0, 1, 25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
